// File: rtl/nibble_serial_adder_pkg.sv
// Shared types for the nibble-serial adder: FSM state encoding and nibble width.
// Build option: OVERFLOW_FLAG_EN (see nibble_serial_adder.sv).
package nsa_pkg;

  localparam int NIB_W   = 4;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_fulladd.sv
// Existing 4-bit combinational adder stage: sum/c_out = a + b + c_in.
// Used one nibble per cycle by nibble_serial_adder.
module fulladd
  import nsa_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             c_in,
  output logic [NIB_W-1:0] sum,
  output logic             c_out
);

  assign {c_out, sum} = {1'b0, a}
                      + {1'b0, b}
                      + {{NIB_W{1'b0}}, c_in};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder, one nibble per cycle LSB first, valid/ready on both sides.
// Define OVERFLOW_FLAG_EN to add the registered signed-overflow output out_ovf.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic [CW-1:0]    count;

  logic [NIB_W-1:0] fa_sum;
  logic             fa_cout;

  logic accept;
  logic running;
  logic last;

  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign running   = (state == S_RUN);
  assign last      = running && (count == LAST);

  fulladd u_fa (
    .a    (a_sr[NIB_W-1:0]),
    .b    (b_sr[NIB_W-1:0]),
    .c_in (carry),
    .sum  (fa_sum),
    .c_out(fa_cout)
  );

  // New nibble enters at the top; after NIBBLES shifts the LSB nibble sits at [3:0].
  assign res_nxt = (res_sr >> NIB_W)
                 | (WIDTH'(fa_sum) << (WIDTH - NIB_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (count == LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry    <= 1'b0;
      count    <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else if (accept) begin
      a_sr  <= in_a;
      b_sr  <= in_b;
      carry <= in_cin;
      count <= '0;
    end else if (running) begin
      a_sr   <= a_sr >> NIB_W;
      b_sr   <= b_sr >> NIB_W;
      carry  <= fa_cout;
      res_sr <= res_nxt;
      count  <= count + 1'b1;
      // Outputs only move here, so they hold through DONE and after the handshake.
      if (last) begin
        out_sum  <= res_nxt;
        out_cout <= fa_cout;
      end
    end
  end

`ifdef OVERFLOW_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ovf <= 1'b0;
    end else if (last) begin
      out_ovf <= (a_sr[NIB_W-1] == b_sr[NIB_W-1])
              && (fa_sum[NIB_W-1] != a_sr[NIB_W-1]);
    end
  end
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomized checks of nibble_serial_adder (WIDTH=16) against an arithmetic model.
// Overflow checks are compiled in when OVERFLOW_FLAG_EN is defined.
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef OVERFLOW_FLAG_EN
  logic         out_ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout)
`ifdef OVERFLOW_FLAG_EN
    ,
    .out_ovf  (out_ovf)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Golden model: {cout,sum} = a + b + cin; ovf from operand/result sign bits.
  function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic cin);
    logic [W:0] full;
    logic       ovf;
    full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full};
  endfunction

  // Offers one operand set, waits for acceptance, scrambles inputs, waits for out_valid.
  task automatic run_op(input  logic [W-1:0] a,
                        input  logic [W-1:0] b,
                        input  logic         cin,
                        output int           lat);
    int n;
    in_a = a;
    in_b = b;
    in_cin = cin;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick;
      n++;
    end
    tick;
    in_valid = 1'b0;
    in_a = W'($urandom);
    in_b = W'($urandom);
    in_cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int acc;
    int done;
    int extra;
    int cyc;
    logic [W+1:0] q[$];
    logic [W+1:0] exp;

    // Reset state
    tick;
    tick;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cout", out_cout, 0);
`ifdef OVERFLOW_FLAG_EN
    chk("rst_out_ovf", out_ovf, 0);
`endif
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);

    // T1 basic, latency
    out_ready = 1'b1;
    run_op(16'h1234, 16'h4321, 1'b0, lat);
    chk("t1_latency", lat, 4);
    chk("t1_sum", out_sum, 32'h5555);
    chk("t1_cout", out_cout, 0);
    tick;
    chk("t1_back_idle_valid", out_valid, 0);
    chk("t1_back_idle_ready", in_ready, 1);
    chk("t1_sum_held", out_sum, 32'h5555);

    // T2 full ripple
    run_op(16'hFFFF, 16'h0000, 1'b1, lat);
    chk("t2_latency", lat, 4);
    chk("t2_sum", out_sum, 0);
    chk("t2_cout", out_cout, 1);
    tick;

    // T3 backpressure with in_valid pulses in DONE
    out_ready = 1'b0;
    run_op(16'hABCD, 16'h1111, 1'b0, lat);
    chk("t3_latency", lat, 4);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      in_a = 16'h0F0F;
      in_b = 16'h0F0F;
      tick;
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_in_ready", in_ready, 0);
      chk("t3_hold_sum", out_sum, 32'hBCDE);
      chk("t3_hold_cout", out_cout, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("t3_release_valid", out_valid, 0);
    chk("t3_release_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) tick;
    chk("t3_no_hidden_op", out_valid, 0);

    // T4 reset in the middle of RUN
    in_a = 16'h1234;
    in_b = 16'h0001;
    in_cin = 1'b0;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    chk("t4_rst_valid", out_valid, 0);
    chk("t4_rst_sum", out_sum, 0);
    chk("t4_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("t4_ready_after_rst", in_ready, 1);
    for (int i = 0; i < 6; i++) tick;
    chk("t4_no_result", out_valid, 0);
    run_op(16'h00FF, 16'h0001, 1'b0, lat);
    chk("t4_latency", lat, 4);
    chk("t4_sum", out_sum, 32'h0100);
    chk("t4_cout", out_cout, 0);
    tick;

`ifdef OVERFLOW_FLAG_EN
    // T5 signed overflow flag
    run_op(16'h7FFF, 16'h0001, 1'b0, lat);
    chk("t5a_sum", out_sum, 32'h8000);
    chk("t5a_cout", out_cout, 0);
    chk("t5a_ovf", out_ovf, 1);
    tick;
    run_op(16'h8000, 16'h8000, 1'b0, lat);
    chk("t5b_sum", out_sum, 0);
    chk("t5b_cout", out_cout, 1);
    chk("t5b_ovf", out_ovf, 1);
    tick;
    run_op(16'h0001, 16'h0001, 1'b0, lat);
    chk("t5c_sum", out_sum, 32'h0002);
    chk("t5c_ovf", out_ovf, 0);
    tick;
`endif

    // T6 random traffic against a scoreboard queue
    acc = 0;
    done = 0;
    extra = 0;
    cyc = 0;
    while ((acc < 1000 || q.size() != 0) && cyc < 60000) begin
      in_valid = (acc < 1000) && ($urandom_range(0, 3) != 0);
      in_a = W'($urandom);
      in_b = W'($urandom);
      in_cin = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (in_valid && in_ready) begin
        q.push_back(model(in_a, in_b, in_cin));
        acc++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          extra++;
        end else begin
          exp = q.pop_front();
          chk("t6_sum", out_sum, 32'(exp[W-1:0]));
          chk("t6_cout", out_cout, 32'(exp[W]));
`ifdef OVERFLOW_FLAG_EN
          chk("t6_ovf", out_ovf, 32'(exp[W+1]));
`endif
          done++;
        end
      end
      tick;
      cyc++;
    end
    in_valid = 1'b0;
    chk("t6_accepted", acc, 1000);
    chk("t6_completed", done, 1000);
    chk("t6_extra_results", extra, 0);
    chk("t6_pending", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
